// File: rtl/usb_wire_bus_resolver.sv
// Shared USB D+/D- wire resolver with line-state tracking,
// contention and SE0 bus-reset detection, and a status register slave.
module usb_wire_bus_resolver #(
  parameter int         NUM_PORTS        = 2,
  parameter int         SE0_RESET_CYCLES = 250,
  parameter int         SE0_CNT_WIDTH    = 10,
  parameter logic [1:0] CONTENTION_VALUE = 2'b00
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_PORTS-1:0]   ctrlOut_i,
  input  logic [2*NUM_PORTS-1:0] dataOut_i,
  input  logic                   dPlusPullup_i,
  input  logic                   dMinusPullup_i,
  output logic [1:0]             usbWireData_o,
  output logic                   contention_o,
  output logic                   busReset_o,
  input  logic [2:0]             address_i,
  input  logic [7:0]             data_i,
  output logic [7:0]             data_o,
  input  logic                   we_i,
  input  logic                   strobe_i,
  output logic                   ack_o
);

  localparam logic [1:0] LS_IDLE   = 2'b00;
  localparam logic [1:0] LS_ACTIVE = 2'b01;
  localparam logic [1:0] LS_SE0    = 2'b10;

  localparam logic [SE0_CNT_WIDTH-1:0] RST_CYC =
    SE0_CNT_WIDTH'(SE0_RESET_CYCLES);
  localparam logic [SE0_CNT_WIDTH-1:0] CNT_ONE = SE0_CNT_WIDTH'(1);
  localparam logic [SE0_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]               r_bus;
  logic                     r_cont;
  logic                     r_brst;
  logic [1:0]               r_state;
  logic [SE0_CNT_WIDTH-1:0] r_cnt;
  logic                     r_stk_c;
  logic                     r_stk_b;
  logic [7:0]               r_ccnt;
  logic [7:0]               r_last;
  logic                     r_force;
  logic                     r_ack;
  logic [7:0]               r_dat;

  logic [1:0]               w_idle;
  logic [3:0]               w_n;
  logic [2:0]               w_idx;
  logic [1:0]               w_solo;
  logic [1:0]               w_bus_nxt;
  logic                     w_cont_nxt;
  logic [1:0]               w_state_nxt;
  logic [SE0_CNT_WIDTH-1:0] w_cnt_nxt;
  logic                     w_brst_nxt;
  logic                     w_acc;
  logic                     w_wr;
  logic                     w_wr_stat;
  logic                     w_wr_cnt;
  logic                     w_wr_ctrl;
  logic                     w_cont_rise;
  logic                     w_brst_rise;
  logic [7:0]               w_rdata;
  logic                     w_unused;

  assign w_idle   = {dPlusPullup_i, dMinusPullup_i};
  assign w_unused = &{1'b0, data_i[7:2]};

  always_comb begin
    w_n    = '0;
    w_idx  = '0;
    w_solo = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (ctrlOut_i[k]) begin
        w_n    = w_n + 4'd1;
        w_idx  = 3'(k);
        w_solo = dataOut_i[2*k +: 2];
      end
    end
  end

  // forceIdle parks the wire at its pull level and hides collisions
  always_comb begin
    w_bus_nxt  = w_idle;
    w_cont_nxt = 1'b0;
    if (!r_force) begin
      unique case (1'b1)
        (w_n == 4'd1): w_bus_nxt = w_solo;
        (w_n >= 4'd2): begin
          w_bus_nxt  = CONTENTION_VALUE;
          w_cont_nxt = 1'b1;
        end
        default: w_bus_nxt = w_idle;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = LS_ACTIVE;
    if (r_bus == w_idle)
      w_state_nxt = LS_IDLE;
    else if (r_bus == 2'b00)
      w_state_nxt = LS_SE0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    if (w_state_nxt == LS_SE0) begin
      if (r_state != LS_SE0)
        w_cnt_nxt = CNT_ONE;
      else if (r_cnt != CNT_MAX)
        w_cnt_nxt = r_cnt + CNT_ONE;
      else
        w_cnt_nxt = r_cnt;
    end
  end

  assign w_brst_nxt  = (w_state_nxt == LS_SE0) &&
                       (w_cnt_nxt >= RST_CYC);
  assign w_cont_rise = w_cont_nxt && !r_cont;
  assign w_brst_rise = w_brst_nxt && !r_brst;

  assign w_acc     = strobe_i && !r_ack;
  assign w_wr      = w_acc && we_i;
  assign w_wr_stat = w_wr && (address_i == 3'd0);
  assign w_wr_cnt  = w_wr && (address_i == 3'd1);
  assign w_wr_ctrl = w_wr && (address_i == 3'd3);

  always_comb begin
    w_rdata = 8'h00;
    unique case (address_i)
      3'd0:    w_rdata = {4'b0, r_state, r_stk_b, r_stk_c};
      3'd1:    w_rdata = r_ccnt;
      3'd2:    w_rdata = r_last;
      3'd3:    w_rdata = {7'b0, r_force};
      default: w_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bus   <= 2'b00;
      r_cont  <= 1'b0;
      r_brst  <= 1'b0;
      r_state <= LS_IDLE;
      r_cnt   <= '0;
      r_stk_c <= 1'b0;
      r_stk_b <= 1'b0;
      r_ccnt  <= 8'h00;
      r_last  <= 8'hFF;
      r_force <= 1'b0;
      r_ack   <= 1'b0;
      r_dat   <= 8'h00;
    end else begin
      r_bus   <= w_bus_nxt;
      r_cont  <= w_cont_nxt;
      r_brst  <= w_brst_nxt;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // a new event edge beats a same-cycle clear
      r_stk_c <= w_cont_rise ||
                 (r_stk_c && !(w_wr_stat && data_i[0]));
      r_stk_b <= w_brst_rise ||
                 (r_stk_b && !(w_wr_stat && data_i[1]));
      if (w_cont_rise) begin
        if (w_wr_cnt)
          r_ccnt <= 8'd1;
        else if (r_ccnt != 8'hFF)
          r_ccnt <= r_ccnt + 8'd1;
      end else if (w_wr_cnt) begin
        r_ccnt <= 8'h00;
      end
      if (w_n == 4'd1)
        r_last <= {5'b0, w_idx};
      if (w_wr_ctrl)
        r_force <= data_i[0];
      r_ack <= w_acc;
      r_dat <= w_acc ? w_rdata : 8'h00;
    end
  end

  assign usbWireData_o = r_bus;
  assign contention_o  = r_cont;
  assign busReset_o    = r_brst;
  assign ack_o         = r_ack;
  assign data_o        = r_dat;

endmodule

// File: doc/usb_wire_bus_resolver.md
# usb_wire_bus_resolver

Synthesizable, parametrised resolver for a shared USB D+/D- wire with NUM_PORTS transceiver agents (host and slave `usbHostSlave` instances, or more). Each agent presents a drive-enable and a {VP,VM} pair. The block produces the registered bus value: the sole driver, the pull-resistor idle level, or a defined contention value. It also records contention events and SE0 bus-reset durations, and exposes status through an 8-bit wishbone-style register slave on the same clock.

## Interface
Parameters:
- NUM_PORTS, 2: number of driving agents (2..8).
- SE0_RESET_CYCLES, 250: consecutive SE0 cycles that qualify as bus reset.
- SE0_CNT_WIDTH, 10: width of the SE0 duration counter; must hold SE0_RESET_CYCLES.
- CONTENTION_VALUE, 2'b00: bus value driven while more than one agent drives.

Ports:
- clk_i  input  1  sole clock.
- rst_i  input  1  reset; synchronous, active-high.
- ctrlOut_i  input  NUM_PORTS  per-port drive enable; bit k is port k.
- dataOut_i  input  2*NUM_PORTS  per-port {VP,VM}; port k at bits [2k+1:2k].
- dPlusPullup_i  input  1  1 = D+ idles high, 0 = D+ idles low.
- dMinusPullup_i  input  1  1 = D- idles high, 0 = D- idles low.
- usbWireData_o  output  2  registered resolved {VP,VM}; same value fans out to every port's USBWireDataIn.
- contention_o  output  1  registered; high while two or more ports drive.
- busReset_o  output  1  high while SE0 held at least SE0_RESET_CYCLES.
- address_i  input  3  register address.
- data_i  input  8  write data.
- data_o  output  8  read data, valid with ack_o.
- we_i  input  1  write enable.
- strobe_i  input  1  access request.
- ack_o  output  1  access acknowledge.

## Operation
- Resolution, driver count n = popcount(ctrlOut_i):
  - n = 0 gives {dPlusPullup_i, dMinusPullup_i}.
  - n = 1 gives that port's pair.
  - n >= 2 gives CONTENTION_VALUE.
- forceIdle (CTRL bit0) overrides resolution to the idle value and masks contention detection.
- Line-state FSM on the registered bus value:
  - LS_IDLE: bus == idle value.
  - LS_ACTIVE: any other non-SE0 value.
  - LS_SE0: bus == 2'b00 and idle value != 2'b00.
- Transitions follow the bus value every cycle. Entering LS_SE0 loads the SE0 counter with 1; it increments while in LS_SE0 and saturates at all-ones.
  - busReset_o = (state == LS_SE0) && counter >= SE0_RESET_CYCLES.
  - Leaving LS_SE0 clears counter and busReset_o on the same edge.
- Registers (address_i):
  - 0 STATUS R/W1C:
    - bit0 contention sticky, bit1 bus-reset sticky.
    - bits[3:2] line state (00 idle, 01 active, 10 SE0).
    - bits[7:4] 0.
  - 1 CONTENTION_COUNT R: 8-bit count of contention rising edges, saturating at 255. Any write clears it.
  - 2 LAST_DRIVER R: index of the last port that drove alone; 8'hFF until the first sole drive.
  - 3 CTRL R/W: bit0 forceIdle; other bits read 0.
  - 4-7: read 0, writes ignored.
- Sticky bits set on the rising edge of contention_o or busReset_o.
- Set wins over a simultaneous W1C clear. A count increment wins over a simultaneous clear, leaving the count at 1.

## Timing
- Bus latency: one cycle from ctrlOut_i/dataOut_i to usbWireData_o and contention_o.
- SE0 detect: busReset_o rises SE0_RESET_CYCLES cycles after the first SE0 cycle on usbWireData_o.
- Access: ack_o rises the cycle after strobe_i is sampled high with ack_o low, and lasts one cycle.
  - A held strobe_i gives an ack every second cycle.
  - Write side effects take effect on the ack edge.
  - data_o is registered with ack_o and is 8'h00 otherwise.
- Reset values:
  - usbWireData_o = 2'b00, contention_o = 0, busReset_o = 0.
  - FSM LS_IDLE, counters 0, stickies 0, LAST_DRIVER 8'hFF, CTRL 0.
  - ack_o = 0, data_o = 8'h00.
- Reset mid-access aborts the access with no ack. Reset during SE0 restarts qualification from zero.

## Test plan
- Idle, no drivers, dPlusPullup_i=1, dMinusPullup_i=0: usbWireData_o=2'b10 one cycle after reset release; STATUS reads 8'h00.
- Port 1 sole driver with 2'b01: bus=2'b01 after 1 cycle; LAST_DRIVER reads 8'h01; state reads active (STATUS=8'h04).
- Ports 0 and 1 both drive for 3 cycles, twice:
  - contention_o high for 3 cycles each time, bus=CONTENTION_VALUE.
  - CONTENTION_COUNT=2, STATUS bit0=1.
  - Write 8'h01 to STATUS clears bit0; a clear in the same cycle as a new contention edge leaves it set.
- Slave drives SE0 for SE0_RESET_CYCLES+5 cycles:
  - busReset_o rises exactly after SE0_RESET_CYCLES cycles and falls the cycle after SE0 ends.
  - STATUS bit1 remains set.
- SE0 for SE0_RESET_CYCLES-1 cycles: busReset_o never asserts.
- Write CTRL=8'h01 while ports collide: contention_o stays 0 and bus=idle value. Assert rst_i mid-read: no ack_o, all outputs at reset values.
